// File: rtl/spike_rate_encoder.sv
// Float firing rate -> Q16.16 phase accumulator -> per-clock spike count and windowed spike total.
// Optional Bernoulli-dithered emission via macro SPIKE_RATE_ENCODER_POISSON_EN.
module spike_rate_encoder #(
    parameter int unsigned DT_SHIFT  = 10,
    parameter int unsigned WINDOW    = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] f_rate,
    input  logic        i_en,
    input  logic        i_clear,
    output logic        o_spike,
    output logic [7:0]  o_spike_now,
    output logic [31:0] o_spike_cnt,
    output logic        o_cnt_valid
);

    localparam logic [31:0] RATE_MAX = 32'h7FFF_FFFF;
    localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);

    logic        sign_bit;
    logic [7:0]  exp_field;
    logic [22:0] frac_field;
    logic [31:0] mant_ext;
    logic [31:0] rate_conv;
    logic [31:0] rate_q16_reg;
    logic [31:0] inc;
    logic [16:0] spike_count;
    logic [32:0] win_wide;
    logic [31:0] win_sum_reg;
    logic [31:0] win_sum_next;
    logic [15:0] win_cnt_reg;
    logic        win_last;
    logic [7:0]  spike_now_sat;
    logic        advance;

    assign sign_bit   = f_rate[31];
    assign exp_field  = f_rate[30:23];
    assign frac_field = f_rate[22:0];
    assign advance    = i_en && !i_clear;

    // Value = {1,mant} * 2^(exp-127-23) * 2^16, i.e. shift by (exp - 134).
    always_comb begin
        mant_ext  = {8'd0, 1'b1, frac_field};
        rate_conv = '0;
        if (sign_bit || exp_field == 8'd0) begin
            rate_conv = '0;
        end else if (exp_field == 8'hFF) begin
            rate_conv = (frac_field == 23'd0) ? RATE_MAX : 32'd0;
        end else if (exp_field >= 8'd142) begin
            rate_conv = RATE_MAX;
        end else if (exp_field < 8'd111) begin
            rate_conv = '0;
        end else if (exp_field >= 8'd134) begin
            rate_conv = mant_ext << (exp_field - 8'd134);
        end else begin
            rate_conv = mant_ext >> (8'd134 - exp_field);
        end
    end

    assign inc = rate_q16_reg >> DT_SHIFT;

`ifdef SPIKE_RATE_ENCODER_POISSON_EN
    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;
    logic        lfsr_fb;

    // Taps 16,14,13,11; integer part is deterministic, fraction becomes a Bernoulli trial.
    always_comb begin
        lfsr_fb     = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
        lfsr_next   = {lfsr_reg[14:0], lfsr_fb};
        spike_count = {1'b0, inc[31:16]} + {16'd0, (lfsr_reg < inc[15:0])};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg <= LFSR_SEED;
        end else if (advance) begin
            lfsr_reg <= lfsr_next;
        end
    end
`else
    logic [15:0] acc_frac_reg;
    logic [15:0] acc_frac_next;
    logic [32:0] phase_sum;

    always_comb begin
        phase_sum     = {17'd0, acc_frac_reg} + {1'b0, inc};
        spike_count   = phase_sum[32:16];
        acc_frac_next = phase_sum[15:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_frac_reg <= '0;
        end else if (i_clear) begin
            acc_frac_reg <= '0;
        end else if (i_en) begin
            acc_frac_reg <= acc_frac_next;
        end
    end
`endif

    // Window total uses the unsaturated count and clamps at all-ones.
    always_comb begin
        win_wide      = {1'b0, win_sum_reg} + {16'd0, spike_count};
        win_sum_next  = win_wide[32] ? 32'hFFFF_FFFF : win_wide[31:0];
        win_last      = (win_cnt_reg == WIN_LAST);
        spike_now_sat = (spike_count > 17'd255) ? 8'hFF : spike_count[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rate_q16_reg <= '0;
            win_sum_reg  <= '0;
            win_cnt_reg  <= '0;
            o_spike      <= 1'b0;
            o_spike_now  <= '0;
            o_spike_cnt  <= '0;
            o_cnt_valid  <= 1'b0;
        end else begin
            rate_q16_reg <= rate_conv;
            o_spike      <= 1'b0;
            o_spike_now  <= '0;
            o_cnt_valid  <= 1'b0;
            if (i_clear) begin
                win_sum_reg <= '0;
                win_cnt_reg <= '0;
            end else if (i_en) begin
                o_spike     <= (spike_count != 17'd0);
                o_spike_now <= spike_now_sat;
                if (win_last) begin
                    o_spike_cnt <= win_sum_next;
                    o_cnt_valid <= 1'b1;
                    win_sum_reg <= '0;
                    win_cnt_reg <= '0;
                end else begin
                    win_sum_reg <= win_sum_next;
                    win_cnt_reg <= win_cnt_reg + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed self-checking bench for spike_rate_encoder (deterministic accumulator build).
module tb_spike_rate_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] f_rate;
    logic        i_en;
    logic        i_clear;
    logic        o_spike;
    logic [7:0]  o_spike_now;
    logic [31:0] o_spike_cnt;
    logic        o_cnt_valid;
    logic        sat_spike;
    logic [7:0]  sat_now;
    logic [31:0] sat_cnt;
    logic        sat_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spike_rate_encoder #(.DT_SHIFT(10), .WINDOW(8), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset), .f_rate(f_rate), .i_en(i_en), .i_clear(i_clear),
        .o_spike(o_spike), .o_spike_now(o_spike_now), .o_spike_cnt(o_spike_cnt),
        .o_cnt_valid(o_cnt_valid)
    );

    // Second instance with no time-step shift to reach the 255 output clamp.
    spike_rate_encoder #(.DT_SHIFT(0), .WINDOW(2), .LFSR_SEED(16'hACE1)) dut_sat (
        .clk(clk), .reset(reset), .f_rate(f_rate), .i_en(i_en), .i_clear(i_clear),
        .o_spike(sat_spike), .o_spike_now(sat_now), .o_spike_cnt(sat_cnt),
        .o_cnt_valid(sat_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then one disabled clock so the conversion register holds the new rate.
    task automatic start(input logic [31:0] rate);
        reset   = 1'b1;
        i_en    = 1'b0;
        i_clear = 1'b0;
        f_rate  = rate;
        tick();
        tick();
        reset = 1'b0;
        tick();
        i_en = 1'b1;
    endtask

    task automatic test_reset();
        start(32'h44800000);
        for (int k = 1; k <= 10; k++) tick();
        n_checks++;
        if (o_spike_now !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_pre_now: got %0d expected 1", o_spike_now);
        end
        reset = 1'b1;
        #2;
        n_checks++;
        if (o_spike !== 1'b0 || o_spike_now !== 8'd0 || o_spike_cnt !== 32'd0 || o_cnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got spike=%0d now=%0d cnt=%0d valid=%0d expected all 0",
                     o_spike, o_spike_now, o_spike_cnt, o_cnt_valid);
        end
        // Restart: the partial window (2 clocks) must be discarded.
        start(32'h44800000);
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_checks++;
            if (o_cnt_valid !== (k == 8)) begin
                n_fail++;
                $display("FAIL reset_restart_valid clk %0d: got %0d expected %0d", k, o_cnt_valid, (k == 8));
            end
        end
        n_checks++;
        if (o_spike_cnt !== 32'd8) begin
            n_fail++;
            $display("FAIL reset_restart_cnt: got %0d expected 8", o_spike_cnt);
        end
    endtask

    task automatic test_rate_1024();
        start(32'h44800000);
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_checks++;
            if (o_spike_now !== 8'd1 || o_spike !== 1'b1 || o_cnt_valid !== ((k % 8) == 0)) begin
                n_fail++;
                $display("FAIL r1024 clk %0d: got now=%0d spike=%0d valid=%0d expected now=1 spike=1 valid=%0d",
                         k, o_spike_now, o_spike, o_cnt_valid, ((k % 8) == 0));
            end
            if ((k % 8) == 0) begin
                n_checks++;
                if (o_spike_cnt !== 32'd8) begin
                    n_fail++;
                    $display("FAIL r1024_cnt clk %0d: got %0d expected 8", k, o_spike_cnt);
                end
            end
        end
    endtask

    task automatic test_rate_256();
        logic [7:0] exp_now;
        start(32'h43800000);
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_now = ((k % 4) == 0) ? 8'd1 : 8'd0;
            n_checks++;
            if (o_spike_now !== exp_now || o_spike !== exp_now[0] || o_cnt_valid !== ((k % 8) == 0)) begin
                n_fail++;
                $display("FAIL r256 clk %0d: got now=%0d spike=%0d valid=%0d expected now=%0d valid=%0d",
                         k, o_spike_now, o_spike, o_cnt_valid, exp_now, ((k % 8) == 0));
            end
            if ((k % 8) == 0) begin
                n_checks++;
                if (o_spike_cnt !== 32'd2) begin
                    n_fail++;
                    $display("FAIL r256_cnt clk %0d: got %0d expected 2", k, o_spike_cnt);
                end
            end
        end
    endtask

    // 1536.0 -> increment 1.5 per clock: counts alternate 1,2; window total 12.
    task automatic test_mantissa();
        logic [7:0] exp_now;
        start(32'h44C00000);
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_now = ((k % 2) == 1) ? 8'd1 : 8'd2;
            n_checks++;
            if (o_spike_now !== exp_now) begin
                n_fail++;
                $display("FAIL r1536_now clk %0d: got %0d expected %0d", k, o_spike_now, exp_now);
            end
        end
        n_checks++;
        if (o_cnt_valid !== 1'b1 || o_spike_cnt !== 32'd12) begin
            n_fail++;
            $display("FAIL r1536_cnt: got valid=%0d cnt=%0d expected valid=1 cnt=12", o_cnt_valid, o_spike_cnt);
        end
    endtask

    task automatic test_neg_nan();
        logic [31:0] rates [4];
        rates = '{32'hC3800000, 32'h7FC00000, 32'h37000000, 32'h00400000};
        start(32'h44800000);
        for (int r = 0; r < 4; r++) begin
            start(rates[r]);
            for (int k = 1; k <= 8; k++) begin
                tick();
                n_checks++;
                if (o_spike_now !== 8'd0 || o_spike !== 1'b0) begin
                    n_fail++;
                    $display("FAIL zero_rate %08h clk %0d: got now=%0d spike=%0d expected 0",
                             rates[r], k, o_spike_now, o_spike);
                end
            end
            n_checks++;
            if (o_cnt_valid !== 1'b1 || o_spike_cnt !== 32'd0) begin
                n_fail++;
                $display("FAIL zero_rate_cnt %08h: got valid=%0d cnt=%0d expected valid=1 cnt=0",
                         rates[r], o_cnt_valid, o_spike_cnt);
            end
        end
    endtask

    task automatic test_inf();
        logic [7:0] exp_now;
        logic [31:0] rates [2];
        rates = '{32'h7F800000, 32'h47000000};
        for (int r = 0; r < 2; r++) begin
            start(rates[r]);
            for (int k = 1; k <= 8; k++) begin
                tick();
                exp_now = (k == 1) ? 8'd31 : 8'd32;
                n_checks++;
                if (o_spike_now !== exp_now) begin
                    n_fail++;
                    $display("FAIL sat_rate %08h clk %0d: got %0d expected %0d", rates[r], k, o_spike_now, exp_now);
                end
                if (k <= 2) begin
                    n_checks++;
                    if (sat_now !== 8'd255 || sat_spike !== 1'b1) begin
                        n_fail++;
                        $display("FAIL now_clamp clk %0d: got now=%0d spike=%0d expected now=255 spike=1",
                                 k, sat_now, sat_spike);
                    end
                end
                if (k == 2) begin
                    n_checks++;
                    if (sat_valid !== 1'b1 || sat_cnt !== 32'd65535) begin
                        n_fail++;
                        $display("FAIL unclamped_window: got valid=%0d cnt=%0d expected valid=1 cnt=65535",
                                 sat_valid, sat_cnt);
                    end
                end
            end
            n_checks++;
            if (o_cnt_valid !== 1'b1 || o_spike_cnt !== 32'd255) begin
                n_fail++;
                $display("FAIL sat_rate_cnt %08h: got valid=%0d cnt=%0d expected valid=1 cnt=255",
                         rates[r], o_cnt_valid, o_spike_cnt);
            end
        end
        // 16384.0 is the largest exponent that is not clamped: 16 spikes every clock.
        start(32'h46800000);
        for (int k = 1; k <= 8; k++) tick();
        n_checks++;
        if (o_spike_now !== 8'd16 || o_spike_cnt !== 32'd128) begin
            n_fail++;
            $display("FAIL r16384: got now=%0d cnt=%0d expected now=16 cnt=128", o_spike_now, o_spike_cnt);
        end
    endtask

    // Rate step without reset: old rate drives one more clock (two-register latency).
    task automatic test_back_to_back();
        logic [7:0] exp_now;
        start(32'h44800000);
        for (int k = 1; k <= 8; k++) tick();
        f_rate = 32'h43800000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_now = (k == 1 || k == 5) ? 8'd1 : 8'd0;
            n_checks++;
            if (o_spike_now !== exp_now) begin
                n_fail++;
                $display("FAIL step_now clk %0d: got %0d expected %0d", k, o_spike_now, exp_now);
            end
        end
        n_checks++;
        if (o_cnt_valid !== 1'b1 || o_spike_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL step_cnt: got valid=%0d cnt=%0d expected valid=1 cnt=2", o_cnt_valid, o_spike_cnt);
        end
    endtask

    task automatic test_enable_clear();
        logic [7:0] exp_now;
        start(32'h43800000);
        for (int k = 1; k <= 11; k++) tick();
        i_en = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++;
            if (o_spike_now !== 8'd0 || o_spike !== 1'b0 || o_cnt_valid !== 1'b0 || o_spike_cnt !== 32'd2) begin
                n_fail++;
                $display("FAIL disabled clk %0d: got now=%0d spike=%0d valid=%0d cnt=%0d expected 0 0 0 2",
                         k, o_spike_now, o_spike, o_cnt_valid, o_spike_cnt);
            end
        end
        // Phase froze at 0.75, so the first resumed clock spikes.
        i_en = 1'b1;
        tick();
        n_checks++;
        if (o_spike_now !== 8'd1) begin
            n_fail++;
            $display("FAIL resume_now: got %0d expected 1", o_spike_now);
        end
        i_clear = 1'b1;
        tick();
        n_checks++;
        if (o_spike_now !== 8'd0 || o_spike !== 1'b0 || o_cnt_valid !== 1'b0 || o_spike_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL clear_cycle: got now=%0d spike=%0d valid=%0d cnt=%0d expected 0 0 0 2",
                     o_spike_now, o_spike, o_cnt_valid, o_spike_cnt);
        end
        i_clear = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_now = ((k % 4) == 0) ? 8'd1 : 8'd0;
            n_checks++;
            if (o_spike_now !== exp_now || o_cnt_valid !== (k == 8)) begin
                n_fail++;
                $display("FAIL after_clear clk %0d: got now=%0d valid=%0d expected now=%0d valid=%0d",
                         k, o_spike_now, o_cnt_valid, exp_now, (k == 8));
            end
        end
        n_checks++;
        if (o_spike_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL after_clear_cnt: got %0d expected 2", o_spike_cnt);
        end
    endtask

    initial begin
        reset   = 1'b1;
        f_rate  = '0;
        i_en    = 1'b0;
        i_clear = 1'b0;
        tick();
        n_checks++;
        if (o_spike !== 1'b0 || o_spike_now !== 8'd0 || o_spike_cnt !== 32'd0 || o_cnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got spike=%0d now=%0d cnt=%0d valid=%0d expected all 0",
                     o_spike, o_spike_now, o_spike_cnt, o_cnt_valid);
        end
        test_reset();
        test_rate_1024();
        test_rate_256();
        test_mantissa();
        test_neg_nan();
        test_inf();
        test_back_to_back();
        test_enable_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
- Rate-to-spike encoder: the transmit end of the spike-count interface that the muscle/force models consume.
- Takes an IEEE-754 single-precision firing rate (spikes/s) and integrates it every clock with a fixed-point phase accumulator.
- Emits a per-clock spike pulse and count, and a windowed integer spike count that feeds a muscle block's i_spike_cnt input directly.
- Sits between neuron/drive models (float domain) and muscle models (integer spike-count domain).

Parameters:
- DT_SHIFT, 10: per-clock time step is 2^-DT_SHIFT s; increment = rate_q16 >> DT_SHIFT.
- WINDOW, 8: number of enabled clocks summed into one o_spike_cnt sample (1..65535).
- LFSR_SEED, 16'hACE1: reset seed for the dither LFSR (optional feature only; must be nonzero).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- f_rate  in  32  IEEE-754 single-precision firing rate, spikes/s.
- i_en  in  1  integrate enable; low freezes accumulator, window counter and LFSR.
- i_clear  in  1  synchronous clear of accumulator, window sum and window counter.
- o_spike  out  1  high on any clock whose spike count is nonzero.
- o_spike_now  out  8  spikes emitted this clock; saturates at 255.
- o_spike_cnt  out  32  spike total of the last completed window.
- o_cnt_valid  out  1  one-cycle pulse when o_spike_cnt updates.

Behaviour:
- Reset: asynchronous, active-high reset.
  - All outputs go to 0.
  - Accumulator, window sum, window counter and the conversion register clear.
  - LFSR loads LFSR_SEED.
- Stage 1, every clock regardless of i_en: register the float converted to unsigned Q16.16 (rate_q16).
  - Sign = 1, or exponent = 0 (denormals flushed): 0.
  - Exponent = 255: NaN gives 0; +inf gives 32'h7FFFFFFF.
  - Unbiased exponent >= 15: saturate to 32'h7FFFFFFF.
  - Unbiased exponent < -16: 0.
  - Otherwise: {1, mantissa} shifted by (exp - 127 - 7), truncated toward zero.
- Stage 2, when i_en = 1:
  - inc = rate_q16 >> DT_SHIFT.
  - sum = {16'b0, acc_frac} + inc, computed at 33 bits.
  - Spike count this clock = sum[32:16]; acc_frac <= sum[15:0].
- Latency: a step on f_rate affects o_spike_now 2 clocks later (1 conversion register, 1 output register).
- o_spike_now saturates at 255. The window sum adds the unsaturated count and saturates at 32'hFFFFFFFF.
- Window counter counts enabled clocks from 0 to WINDOW-1. On the enabled clock where it equals WINDOW-1:
  - o_spike_cnt <= window sum including this clock's count.
  - o_cnt_valid pulses for one clock.
  - Window sum and window counter restart at 0.
- i_en = 0: o_spike and o_spike_now are 0; all state holds; o_cnt_valid does not fire.
- i_clear = 1:
  - acc_frac, window sum and window counter go to 0.
  - o_spike, o_spike_now and o_cnt_valid are 0 that cycle.
  - o_spike_cnt holds its last value.
  - i_clear has priority over i_en.
- A reset asserted mid-window discards the partial window; no o_cnt_valid is produced.

Optional Feature:
- Macro: SPIKE_RATE_ENCODER_POISSON_EN.
- Defined: stochastic emission replaces the phase accumulator.
  - Integer part inc[31:16] is emitted deterministically.
  - One extra spike is emitted when lfsr[15:0] < inc[15:0].
  - LFSR is a 16-bit Fibonacci LFSR, taps 16,14,13,11; it steps on every enabled, non-cleared clock.
  - acc_frac stays at 0.
  - Mean rate is preserved; spike timing is Bernoulli-dithered.
- Undefined: deterministic accumulator as described in Behaviour; no LFSR logic is synthesized.

Test Plan:
- DT_SHIFT = 10, WINDOW = 8, f_rate = 32'h44800000 (1024.0), i_en = 1 -> o_spike_now = 1 every clock; o_spike_cnt = 8 with o_cnt_valid once every 8 clocks.
- f_rate = 32'h43800000 (256.0) from reset -> o_spike on every 4th enabled clock; each window o_spike_cnt = 2.
- f_rate = 32'hC3800000 (-256.0), then 32'h7FC00000 (NaN) -> o_spike stays 0; o_spike_cnt = 0.
- f_rate = 32'h7F800000 (+inf) -> inc = 32'h001FFFFF; o_spike_now is 31 or 32 per clock; first window o_spike_cnt = 255.
- At 256.0, drop i_en for 5 clocks mid-window, then toggle i_clear for 1 clock -> nothing advances while i_en = 0; after i_clear the next o_cnt_valid comes exactly 8 enabled clocks later with count 2; o_spike_cnt holds across the clear.
- SPIKE_RATE_ENCODER_POISSON_EN defined, f_rate = 256.0, WINDOW = 1024 -> o_spike_cnt within 256 ± 48; reset reproduces the identical spike sequence.
